fft_in_packer: RTL and testbench

Upstream input stage for the 512-point FFT. Accepts one complex 9-bit sample per cycle, assembles 512-sample frames in a ping-pong buffer, and replays each full frame as a contiguous 32-beat burst of 16 parallel lanes. This produces exactly the `din_valid`/`din_i`/`din_q` stream that `module0` consumes. Input gaps are absorbed; output bursts never contain gaps.

---
 rtl/fft_in_packer.sv | 155 +++++++++++++++
 tb/tb_fft_in_packer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_in_packer.sv
// Input stage for the 512-point FFT: collects serial complex samples into a
// ping-pong frame buffer and replays each full frame as a gapless 16-lane burst.
module fft_in_packer #(
    parameter int N_FFT = 512,
    parameter int LANES = 16,
    parameter int W     = 9
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sample_valid,
    input  logic                sample_sof,
    input  logic signed [W-1:0] sample_i,
    input  logic signed [W-1:0] sample_q,
    output logic                din_valid,
    output logic signed [W-1:0] din_i [0:LANES-1],
    output logic signed [W-1:0] din_q [0:LANES-1],
    output logic                frame_drop
);

    localparam int BEATS  = N_FFT / LANES;
    localparam int CNT_W  = $clog2(N_FFT);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    logic [2*W-1:0]    mem [0:2*N_FFT-1];

    logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
    logic              wrBank_q, wrBank_d;
    logic [1:0]        full_q, full_d;
    logic              frameDrop_q, frameDrop_d;
    logic [CNT_W-1:0]  wrIdx;
    logic [1:0]        setFull;

    state_t            state_q, state_d;
    logic              rdBank_q, rdBank_d;
    logic [BEAT_W-1:0] rdBeat_q, rdBeat_d;
    logic [1:0]        clrFull;
    logic              emit;
    logic              emitBank;
    logic [BEAT_W-1:0] emitBeat;

    logic              dinValid_q;
    logic signed [W-1:0] dinI_q [0:LANES-1];
    logic signed [W-1:0] dinQ_q [0:LANES-1];

    // An SOF sample always lands at index 0; if a frame was in progress it is abandoned.
    always_comb begin
        wrCnt_d     = wrCnt_q;
        wrBank_d    = wrBank_q;
        wrIdx       = wrCnt_q;
        setFull     = '0;
        frameDrop_d = 1'b0;
        if (sample_valid) begin
            if (sample_sof) begin
                wrIdx       = '0;
                wrCnt_d     = CNT_W'(1);
                frameDrop_d = (wrCnt_q != '0);
            end else if (wrCnt_q == CNT_W'(N_FFT - 1)) begin
                wrCnt_d           = '0;
                wrBank_d          = ~wrBank_q;
                setFull[wrBank_q] = 1'b1;
            end else begin
                wrCnt_d = wrCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sample_valid) begin
            mem[{wrBank_q, wrIdx}] <= {sample_i, sample_q};
        end
    end

    // Beat 0 is emitted straight from IDLE so the first beat appears one edge after the bank fills.
    always_comb begin
        state_d  = state_q;
        rdBank_d = rdBank_q;
        rdBeat_d = rdBeat_q;
        clrFull  = '0;
        emit     = 1'b0;
        emitBank = rdBank_q;
        emitBeat = rdBeat_q;
        case (state_q)
            IDLE: begin
                if (|full_q) begin
                    emit     = 1'b1;
                    emitBank = (&full_q) ? ~wrBank_q : full_q[1];
                    emitBeat = '0;
                    rdBank_d = emitBank;
                    rdBeat_d = BEAT_W'(1);
                    state_d  = BURST;
                end
            end
            BURST: begin
                emit     = 1'b1;
                rdBeat_d = rdBeat_q + BEAT_W'(1);
                if (rdBeat_q == BEAT_W'(BEATS - 1)) begin
                    clrFull[rdBank_q] = 1'b1;
                    if (full_q[~rdBank_q]) begin
                        rdBank_d = ~rdBank_q;
                        rdBeat_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign full_d = (full_q & ~clrFull) | setFull;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wrCnt_q     <= '0;
            wrBank_q    <= 1'b0;
            full_q      <= '0;
            frameDrop_q <= 1'b0;
            state_q     <= IDLE;
            rdBank_q    <= 1'b0;
            rdBeat_q    <= '0;
            dinValid_q  <= 1'b0;
            for (int j = 0; j < LANES; j++) begin
                dinI_q[j] <= '0;
                dinQ_q[j] <= '0;
            end
        end else begin
            wrCnt_q     <= wrCnt_d;
            wrBank_q    <= wrBank_d;
            full_q      <= full_d;
            frameDrop_q <= frameDrop_d;
            state_q     <= state_d;
            rdBank_q    <= rdBank_d;
            rdBeat_q    <= rdBeat_d;
            dinValid_q  <= emit;
            if (emit) begin
                for (int j = 0; j < LANES; j++) begin
                    dinI_q[j] <= mem[{emitBank, emitBeat, LANE_W'(j)}][2*W-1:W];
                    dinQ_q[j] <= mem[{emitBank, emitBeat, LANE_W'(j)}][W-1:0];
                end
            end
        end
    end

    assign din_valid  = dinValid_q;
    assign din_i      = dinI_q;
    assign din_q      = dinQ_q;
    assign frame_drop = frameDrop_q;

endmodule

// File: tb/tb_fft_in_packer.sv
// Scoreboard bench for fft_in_packer: a reference frame model queues the expected
// beats as samples are driven, and a negedge monitor pops and compares them.
module tb_fft_in_packer;

    localparam int N  = 512;
    localparam int L  = 16;
    localparam int W  = 9;
    localparam int BW = L * 2 * W;

    logic                clk;
    logic                rstn;
    logic                sample_valid;
    logic                sample_sof;
    logic signed [W-1:0] sample_i;
    logic signed [W-1:0] sample_q;
    logic                din_valid;
    logic signed [W-1:0] din_i [0:L-1];
    logic signed [W-1:0] din_q [0:L-1];
    logic                frame_drop;

    fft_in_packer dut (
        .clk          (clk),
        .rstn         (rstn),
        .sample_valid (sample_valid),
        .sample_sof   (sample_sof),
        .sample_i     (sample_i),
        .sample_q     (sample_q),
        .din_valid    (din_valid),
        .din_i        (din_i),
        .din_q        (din_q),
        .frame_drop   (frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt++;

    logic [BW-1:0]    expQ [$];
    logic [2*W-1:0]   mBuf [0:N-1];
    int               mCnt = 0;
    int               lastCapture = 0;

    int               runLen = 0;
    int               burstCount = 0;
    int               dropCount = 0;
    int               burstStarts [$];
    logic [BW-1:0]    monGot;
    logic [BW-1:0]    monExp;

    function automatic logic [BW-1:0] packLanes();
        logic [BW-1:0] p;
        for (int j = 0; j < L; j++) p[j*2*W +: 2*W] = {din_i[j], din_q[j]};
        return p;
    endfunction

    // Output monitor: every valid beat must match the head of the scoreboard, bursts are 32 long.
    always @(negedge clk) begin
        if (rstn) begin
            runLen = 0;
        end else begin
            if (din_valid) begin
                if (runLen == 0) burstStarts.push_back(cycleCnt);
                runLen++;
                compared++;
                monGot = packLanes();
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got %h, required no beat", monGot);
                end else begin
                    monExp = expQ.pop_front();
                    if (monGot !== monExp) begin
                        mismatched++;
                        $display("[TB] FAIL beat_data: got %h, required %h", monGot, monExp);
                    end
                end
            end else if (runLen != 0) begin
                compared++;
                if (runLen != 32) begin
                    mismatched++;
                    $display("[TB] FAIL burst_len: got %0d, required 32", runLen);
                end
                burstCount++;
                runLen = 0;
            end
            if (frame_drop) dropCount++;
        end
    end

    task automatic sendSample(input logic signed [W-1:0] si, input logic signed [W-1:0] sq,
                              input logic sof);
        logic [BW-1:0] beat;
        @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_sof   = sof;
        sample_i     = si;
        sample_q     = sq;
        lastCapture  = cycleCnt + 1;
        if (sof) begin
            mBuf[0] = {si, sq};
            mCnt    = 1;
        end else begin
            mBuf[mCnt] = {si, sq};
            if (mCnt == N - 1) begin
                for (int b = 0; b < N / L; b++) begin
                    for (int j = 0; j < L; j++) beat[j*2*W +: 2*W] = mBuf[b*L + j];
                    expQ.push_back(beat);
                end
                mCnt = 0;
            end else begin
                mCnt++;
            end
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_sof   = 1'b0;
    endtask

    task automatic test_reset();
        rstn         = 1'b1;
        sample_valid = 1'b0;
        sample_sof   = 1'b0;
        sample_i     = '0;
        sample_q     = '0;
        repeat (3) @(negedge clk);
        compared += 3;
        if (din_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %b, required 0", din_valid);
        end
        if (frame_drop !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_drop: got %b, required 0", frame_drop);
        end
        if (packLanes() !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_lanes: got %h, required 0", packLanes());
        end
        rstn = 1'b0;
    endtask

    task automatic test_single_frame();
        int b0 = burstCount;
        int s0 = burstStarts.size();
        int cap;
        int si;
        for (int k = 0; k < N; k++) begin
            si = (k % 256) - 128;
            sendSample(W'(si), W'(-si), 1'b0);
        end
        cap = lastCapture;
        idleCycle();
        for (int c = 0; c < 100 && burstCount < b0 + 1; c++) @(negedge clk);
        compared += 2;
        if (burstCount !== b0 + 1) begin
            mismatched++;
            $display("[TB] FAIL single_bursts: got %0d, required %0d", burstCount - b0, 1);
        end
        if (burstStarts.size() <= s0 || burstStarts[s0] != cap + 1) begin
            mismatched++;
            $display("[TB] FAIL single_latency: got start %0d, required %0d",
                     (burstStarts.size() > s0) ? burstStarts[s0] : -1, cap + 1);
        end
    endtask

    task automatic test_gappy();
        int b0 = burstCount;
        int s0 = burstStarts.size();
        int cap;
        int si;
        for (int k = 0; k < N; k++) begin
            si = (k % 256) - 128;
            sendSample(W'(si), W'(-si), 1'b0);
            if (k == N - 1) cap = lastCapture;
            idleCycle();
        end
        for (int c = 0; c < 100 && burstCount < b0 + 1; c++) @(negedge clk);
        compared += 2;
        if (burstCount !== b0 + 1) begin
            mismatched++;
            $display("[TB] FAIL gappy_bursts: got %0d, required 1", burstCount - b0);
        end
        if (burstStarts.size() <= s0 || burstStarts[s0] != cap + 1) begin
            mismatched++;
            $display("[TB] FAIL gappy_latency: got start %0d, required %0d",
                     (burstStarts.size() > s0) ? burstStarts[s0] : -1, cap + 1);
        end
    endtask

    task automatic test_back_to_back();
        int b0 = burstCount;
        int d0 = dropCount;
        int s0 = burstStarts.size();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) sendSample(W'(f + 1), W'(f + 1), k == 0);
        end
        idleCycle();
        for (int c = 0; c < 200 && burstCount < b0 + 3; c++) @(negedge clk);
        compared += 3;
        if (burstCount !== b0 + 3) begin
            mismatched++;
            $display("[TB] FAIL b2b_bursts: got %0d, required 3", burstCount - b0);
        end
        if (dropCount !== d0) begin
            mismatched++;
            $display("[TB] FAIL b2b_no_drop: got %0d drops, required 0", dropCount - d0);
        end
        if (burstStarts.size() < s0 + 3 ||
            burstStarts[s0 + 1] - burstStarts[s0] != 512 ||
            burstStarts[s0 + 2] - burstStarts[s0 + 1] != 512) begin
            mismatched++;
            $display("[TB] FAIL b2b_spacing: got %0d starts with uneven spacing, required 3 at 512",
                     burstStarts.size() - s0);
        end
    endtask

    task automatic test_sof_truncation();
        int b0 = burstCount;
        int d0 = dropCount;
        for (int k = 0; k < 100; k++) sendSample(W'(k - 50), W'(50 - k), 1'b0);
        sendSample(-9'sd256, 9'sd100, 1'b1);
        sendSample(W'(7 - 256), W'(255 - 1), 1'b0);
        @(negedge clk);
        compared++;
        if (frame_drop !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drop_pulse: got %b, required 1", frame_drop);
        end
        sendSample(W'(14 - 256), W'(255 - 2), 1'b0);
        @(negedge clk);
        compared++;
        if (frame_drop !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drop_width: got %b, required 0", frame_drop);
        end
        for (int k = 3; k < N; k++) sendSample(W'(((k * 7) % 512) - 256), W'(255 - k), 1'b0);
        idleCycle();
        for (int c = 0; c < 100 && burstCount < b0 + 1; c++) @(negedge clk);
        compared += 2;
        if (burstCount !== b0 + 1) begin
            mismatched++;
            $display("[TB] FAIL sof_bursts: got %0d, required 1", burstCount - b0);
        end
        if (dropCount !== d0 + 1) begin
            mismatched++;
            $display("[TB] FAIL sof_drops: got %0d, required 1", dropCount - d0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int b0;
        int hit = 0;
        for (int k = 0; k < N; k++) sendSample(W'(k % 200), W'(-(k % 200)), 1'b0);
        idleCycle();
        for (int c = 0; c < 100 && hit == 0; c++) begin
            @(negedge clk);
            #1;
            if (runLen == 10) hit = 1;
        end
        compared++;
        if (hit != 1) begin
            mismatched++;
            $display("[TB] FAIL reset_beat10: got runLen %0d, required 10", runLen);
        end
        rstn = 1'b1;
        #1;
        compared += 2;
        if (din_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_valid: got %b, required 0", din_valid);
        end
        if (packLanes() !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_mid_lanes: got %h, required 0", packLanes());
        end
        expQ.delete();
        mCnt = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        b0 = burstCount;
        for (int k = 0; k < N; k++) sendSample(W'(100 - (k % 300)), W'(k % 255), 1'b0);
        idleCycle();
        for (int c = 0; c < 100 && burstCount < b0 + 1; c++) @(negedge clk);
        repeat (40) @(negedge clk);
        compared++;
        if (burstCount !== b0 + 1) begin
            mismatched++;
            $display("[TB] FAIL rst_fresh_bursts: got %0d, required 1", burstCount - b0);
        end
    endtask

    task automatic test_extremes();
        int b0 = burstCount;
        logic signed [W-1:0] v;
        for (int k = 0; k < N; k++) begin
            v = (k % 2 == 0) ? -9'sd256 : 9'sd255;
            sendSample(v, v, 1'b0);
        end
        idleCycle();
        for (int c = 0; c < 100 && burstCount < b0 + 1; c++) @(negedge clk);
        compared++;
        if (burstCount !== b0 + 1) begin
            mismatched++;
            $display("[TB] FAIL extreme_bursts: got %0d, required 1", burstCount - b0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gappy();
        test_back_to_back();
        test_sof_truncation();
        test_reset_mid_burst();
        test_extremes();
        repeat (5) @(negedge clk);
        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL leftover_beats: got %0d pending, required 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
